spi_master_controller: RTL and testbench

SPI_MASTER_CONTROLLER -- requirements
Module: spi_master_controller

---
 rtl/spi_master_pkg.sv | 41 ++++
 rtl/spi_master_controller_clk_gen.sv | 34 +++
 rtl/spi_master_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_master_controller.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master controller.
// Holds the FSM state enum, opcodes, command field positions and length limits.
package spi_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_HDR,
      ST_WDATA,
      ST_RDATA,
      ST_STOP,
      ST_EOT
   } state_e;

   localparam logic [3:0] OP_WRITE = 4'hA;
   localparam logic [3:0] OP_READ  = 4'hB;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 28;
   localparam int HDR_MSB = 27;
   localparam int HDR_LSB = 24;
   localparam int LEN_MSB = 23;
   localparam int LEN_LSB = 16;
   localparam int WD_MSB  = 15;
   localparam int WD_LSB  = 0;

   localparam logic [7:0] MAX_WR_LEN = 8'd16;
   localparam logic [7:0] MAX_RD_LEN = 8'd32;
   localparam logic [7:0] DIV_RST    = 8'd4;

   // Last counter value of a half-period; a divider of 0 behaves as 1.
   function automatic logic [7:0] half_last(input logic [7:0] div);
      return (div == 8'd0) ? 8'd0 : div - 8'd1;
   endfunction

   function automatic logic [5:0] clamp_len(input logic [7:0] n,
                                            input logic [7:0] lim);
      return (n > lim) ? lim[5:0] : n[5:0];
   endfunction

endpackage

// File: rtl/spi_master_controller_clk_gen.sv
// Half-period tick generator for the SPI master.
// Ports: clk_i, rst_n_i, en_i (run), div_i (half-period), tick_o (last cycle).
module spi_clk_gen
   import spi_master_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       en_i,
   input  logic [7:0] div_i,
   output logic       tick_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tick_o = en_i && (cnt_q == half_last(div_i));

   // Counter idles at zero so the first half-period after enable is full.
   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (!en_i || tick_o) begin
         cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master_controller.sv
// SPI mode-0 master driven by a 32-bit command stream; returns read results.
// Ports: clk/rst, divider load, tx cmd stream, rx result stream, SPI pins, eot.
module spi_master_controller
   import spi_master_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [7:0]  spi_clk_div_i,
   input  logic        spi_clk_div_vld_i,
   input  logic [31:0] stream_data_tx_i,
   input  logic        stream_data_tx_vld_i,
   output logic        stream_data_tx_rdy_o,
   output logic [31:0] stream_data_rx_o,
   output logic        stream_data_rx_vld_o,
   input  logic        stream_data_rx_rdy_i,
   output logic        spi_clk_o,
   output logic        spi_cs_n_o,
   output logic        spi_sdo_o,
   input  logic        spi_sdi_i,
   output logic        eot_o
);

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic        rd_q, rd_d;
   logic [3:0]  hdr_q, hdr_d;
   logic [15:0] wdat_q, wdat_d;
   logic [5:0]  len_q, len_d;
   logic [5:0]  bit_q, bit_d;
   logic        ph_q, ph_d;
   logic [31:0] sh_q, sh_d;
   logic [31:0] rx_q, rx_d;
   logic        rx_vld_q, rx_vld_d;
   logic        rdy_q, rdy_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        sdo_q, sdo_d;
   logic        eot_q, eot_d;

   logic        tick;
   logic        active;
   logic        accept;
   logic        spi_rx_en;
   logic [3:0]  opc;
   logic [7:0]  nfld;
   logic [5:0]  bit_nxt;
   logic [5:0]  len_m1;

   assign opc     = stream_data_tx_i[OP_MSB:OP_LSB];
   assign nfld    = stream_data_tx_i[LEN_MSB:LEN_LSB];
   assign accept  = rdy_q && stream_data_tx_vld_i;
   assign bit_nxt = bit_q - 6'd1;
   assign len_m1  = len_q - 6'd1;

   assign active = (state_q == ST_START) || (state_q == ST_HDR) ||
                   (state_q == ST_WDATA) || (state_q == ST_RDATA) ||
                   (state_q == ST_STOP);

   assign spi_rx_en = (state_q == ST_RDATA);

   spi_clk_gen u_clk_gen (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (active),
      .div_i   (div_q),
      .tick_o  (tick)
   );

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      rd_d     = rd_q;
      hdr_d    = hdr_q;
      wdat_d   = wdat_q;
      len_d    = len_q;
      bit_d    = bit_q;
      ph_d     = ph_q;
      sh_d     = sh_q;
      rx_d     = rx_q;
      rx_vld_d = rx_vld_q;
      cs_n_d   = cs_n_q;
      sclk_d   = sclk_q;
      sdo_d    = sdo_q;
      eot_d    = 1'b0;

      if (rx_vld_q && stream_data_rx_rdy_i) begin
         rx_vld_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (spi_clk_div_vld_i) begin
               div_d = spi_clk_div_i;
            end
            if (accept) begin
               hdr_d  = stream_data_tx_i[HDR_MSB:HDR_LSB];
               wdat_d = stream_data_tx_i[WD_MSB:WD_LSB];
               sh_d   = 32'd0;
               rd_d   = (opc == OP_READ);
               len_d  = (opc == OP_READ) ?
                        clamp_len(nfld, MAX_RD_LEN) :
                        clamp_len(nfld, MAX_WR_LEN);
               if ((opc == OP_WRITE) || (opc == OP_READ)) begin
                  state_d = ST_START;
                  cs_n_d  = 1'b0;
               end else begin
                  state_d = ST_EOT;
                  eot_d   = 1'b1;
               end
            end
         end

         ST_START: begin
            if (tick) begin
               state_d = ST_HDR;
               bit_d   = 6'd3;
               ph_d    = 1'b0;
               sdo_d   = hdr_q[3];
            end
         end

         ST_HDR, ST_WDATA, ST_RDATA: begin
            if (tick) begin
               if (!ph_q) begin
                  // End of low half: clock rises, sample the slave now.
                  sclk_d = 1'b1;
                  ph_d   = 1'b1;
                  if (spi_rx_en) begin
                     sh_d = {sh_q[30:0], spi_sdi_i};
                  end
               end else begin
                  // End of high half: clock falls, next bit goes out.
                  sclk_d = 1'b0;
                  ph_d   = 1'b0;
                  if (bit_q != 6'd0) begin
                     bit_d = bit_nxt;
                     if (state_q == ST_HDR) begin
                        sdo_d = hdr_q[bit_nxt[1:0]];
                     end else if (state_q == ST_WDATA) begin
                        sdo_d = wdat_q[bit_nxt[3:0]];
                     end else begin
                        sdo_d = 1'b0;
                     end
                  end else if ((state_q == ST_HDR) &&
                               (len_q != 6'd0)) begin
                     bit_d = len_m1;
                     if (rd_q) begin
                        state_d = ST_RDATA;
                        sdo_d   = 1'b0;
                     end else begin
                        state_d = ST_WDATA;
                        sdo_d   = wdat_q[len_m1[3:0]];
                     end
                  end else begin
                     state_d = ST_STOP;
                     sdo_d   = 1'b0;
                  end
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               state_d = ST_EOT;
               cs_n_d  = 1'b1;
               eot_d   = 1'b1;
               if (rd_q) begin
                  rx_d     = sh_q;
                  rx_vld_d = 1'b1;
               end
            end
         end

         ST_EOT: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Ready is registered, so derive it from next-state values.
      rdy_d = (state_d == ST_IDLE) && !rx_vld_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         div_q    <= DIV_RST;
         rd_q     <= 1'b0;
         hdr_q    <= 4'd0;
         wdat_q   <= 16'd0;
         len_q    <= 6'd0;
         bit_q    <= 6'd0;
         ph_q     <= 1'b0;
         sh_q     <= 32'd0;
         rx_q     <= 32'd0;
         rx_vld_q <= 1'b0;
         rdy_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         sclk_q   <= 1'b0;
         sdo_q    <= 1'b0;
         eot_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         rd_q     <= rd_d;
         hdr_q    <= hdr_d;
         wdat_q   <= wdat_d;
         len_q    <= len_d;
         bit_q    <= bit_d;
         ph_q     <= ph_d;
         sh_q     <= sh_d;
         rx_q     <= rx_d;
         rx_vld_q <= rx_vld_d;
         rdy_q    <= rdy_d;
         cs_n_q   <= cs_n_d;
         sclk_q   <= sclk_d;
         sdo_q    <= sdo_d;
         eot_q    <= eot_d;
      end
   end

   assign stream_data_tx_rdy_o = rdy_q;
   assign stream_data_rx_o     = rx_q;
   assign stream_data_rx_vld_o = rx_vld_q;
   assign spi_clk_o            = sclk_q;
   assign spi_cs_n_o           = cs_n_q;
   assign spi_sdo_o            = sdo_q;
   assign eot_o                = eot_q;

endmodule

// File: tb/tb_spi_master_controller.sv
// Scoreboard bench for spi_master_controller.
// Expected SPI frames, eot pulses and read results are queued at command issue.
module tb_spi_master_controller;

   typedef struct {
      logic [63:0] bits;
      int          nb;
      int          cs_len;
      int          per;
      int          rxen;
   } spi_exp_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  div_in;
   logic        div_vld;
   logic [31:0] tx_data;
   logic        tx_vld;
   logic        tx_rdy;
   logic [31:0] rx_data;
   logic        rx_vld;
   logic        rx_rdy;
   logic        sclk;
   logic        cs_n;
   logic        sdo;
   logic        sdi;
   logic        eot;

   spi_master_controller dut (
      .clk_i                (clk),
      .rst_n_i              (rst_n),
      .spi_clk_div_i        (div_in),
      .spi_clk_div_vld_i    (div_vld),
      .stream_data_tx_i     (tx_data),
      .stream_data_tx_vld_i (tx_vld),
      .stream_data_tx_rdy_o (tx_rdy),
      .stream_data_rx_o     (rx_data),
      .stream_data_rx_vld_o (rx_vld),
      .stream_data_rx_rdy_i (rx_rdy),
      .spi_clk_o            (sclk),
      .spi_cs_n_o           (cs_n),
      .spi_sdo_o            (sdo),
      .spi_sdi_i            (sdi),
      .eot_o                (eot)
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;

   spi_exp_t    exp_spi[$];
   logic [31:0] exp_rx[$];
   logic        exp_eot[$];

   int          div_model = 4;
   int          cur_n = 0;
   logic [31:0] sdi_word = 32'd0;
   logic        bp_hold = 1'b0;
   logic        bp_rand = 1'b0;
   logic        mon_en = 1'b0;
   int          idle_viol = 0;
   int          rdy_viol = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   function automatic int eff_n(input logic [31:0] c);
      int n;
      n = int'(c[23:16]);
      if (c[31:28] == 4'hA && n > 16) n = 16;
      if (c[31:28] == 4'hB && n > 32) n = 32;
      return n;
   endfunction

   // Frame shape from the protocol rules: header, payload, timing totals.
   function automatic spi_exp_t model_spi(input logic [31:0] c, input int d);
      spi_exp_t e;
      int n;
      logic wr;
      n = eff_n(c);
      wr = (c[31:28] == 4'hA);
      e.bits = 64'(c[27:24]);
      for (int i = n - 1; i >= 0; i--)
         e.bits = {e.bits[62:0], wr ? c[i] : 1'b0};
      e.nb = 4 + n;
      e.cs_len = d * (2 + 2 * (4 + n));
      e.per = 2 * d;
      e.rxen = wr ? 0 : 2 * d * n;
      return e;
   endfunction

   // Slave model: next read bit presented after each falling spi clock.
   initial begin
      int fc;
      int k;
      logic pc;
      logic ps;
      fc = 0;
      pc = 1'b1;
      ps = 1'b0;
      sdi = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (pc && !cs_n) fc = 0;
         if (ps && !sclk) begin
            fc++;
            k = fc - 4;
            sdi = (k >= 0 && k < cur_n) ? sdi_word[cur_n - 1 - k] : 1'b0;
         end
         pc = cs_n;
         ps = sclk;
      end
   end

   initial begin
      rx_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (bp_hold) rx_rdy = 1'b0;
         else if (bp_rand) rx_rdy = ($urandom_range(0, 2) == 0);
         else rx_rdy = 1'b1;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a response.
   initial begin
      logic in_tr;
      logic prev_sclk;
      logic hs_prev;
      logic [63:0] m_bits;
      int m_nb, m_cs, m_since, m_pmin, m_pmax, m_rxen;
      spi_exp_t se;
      logic er;
      logic [31:0] ed;
      in_tr = 1'b0;
      prev_sclk = 1'b0;
      hs_prev = 1'b0;
      m_bits = '0;
      m_nb = 0; m_cs = 0; m_since = 0; m_pmin = 0; m_pmax = 0; m_rxen = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_tr = 1'b0;
            prev_sclk = 1'b0;
            hs_prev = 1'b0;
         end else if (mon_en) begin
            if (hs_prev) chk("rx_vld_clear", rx_vld, 1'b0);
            hs_prev = rx_vld && rx_rdy;
            if (rx_vld && tx_rdy) rdy_viol++;
            if (rx_vld && rx_rdy) begin
               if (exp_rx.size() == 0) chk("unexpected_rx", 1, 0);
               else begin
                  ed = exp_rx.pop_front();
                  chk("rx_data", rx_data, ed);
               end
            end
            if (eot) begin
               if (exp_eot.size() == 0) chk("unexpected_eot", 1, 0);
               else begin
                  er = exp_eot.pop_front();
                  if (er) chk("rx_vld_at_eot", rx_vld, 1'b1);
               end
            end
            if (!cs_n) begin
               if (!in_tr) begin
                  in_tr = 1'b1;
                  m_bits = '0; m_nb = 0; m_cs = 0; m_since = 0;
                  m_pmin = 1000000; m_pmax = 0; m_rxen = 0;
               end
               m_cs++;
               m_since++;
               if (dut.spi_rx_en) m_rxen++;
               if (sclk && !prev_sclk) begin
                  if (m_nb > 0) begin
                     if (m_since < m_pmin) m_pmin = m_since;
                     if (m_since > m_pmax) m_pmax = m_since;
                  end
                  m_since = 0;
                  m_bits = {m_bits[62:0], sdo};
                  m_nb++;
               end
            end else if (in_tr) begin
               in_tr = 1'b0;
               if (exp_spi.size() == 0) chk("unexpected_spi", 1, 0);
               else begin
                  se = exp_spi.pop_front();
                  chk("spi_pulses", m_nb, se.nb);
                  chk("spi_sdo_bits", m_bits, se.bits);
                  chk("cs_low_cycles", m_cs, se.cs_len);
                  chk("sclk_period_min", m_pmin, se.per);
                  chk("sclk_period_max", m_pmax, se.per);
                  chk("rx_en_cycles", m_rxen, se.rxen);
               end
               chk("eot_at_cs_rise", eot, 1'b1);
            end else if (sclk || sdo) begin
               idle_viol++;
            end
            prev_sclk = sclk;
         end
      end
   end

   task automatic send(input logic [31:0] c, input logic [31:0] rd);
      int t;
      int n;
      @(negedge clk);
      tx_data = c;
      tx_vld = 1'b1;
      t = 0;
      while (!tx_rdy && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!tx_rdy) begin
         chk("accept_timeout", 0, 1);
         tx_vld = 1'b0;
         return;
      end
      n = eff_n(c);
      if (c[31:28] == 4'hB) begin
         cur_n = n;
         sdi_word = rd;
         exp_rx.push_back(32'(rd & ((64'd1 << n) - 64'd1)));
      end else begin
         cur_n = 0;
      end
      if (c[31:28] == 4'hA || c[31:28] == 4'hB)
         exp_spi.push_back(model_spi(c, div_model));
      exp_eot.push_back(c[31:28] == 4'hB);
      @(posedge clk);
      #1;
      tx_vld = 1'b0;
   endtask

   task automatic set_div(input logic [7:0] d);
      @(negedge clk);
      div_in = d;
      div_vld = 1'b1;
      @(negedge clk);
      div_vld = 1'b0;
      div_model = (d == 8'd0) ? 1 : int'(d);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((exp_eot.size() + exp_rx.size() + exp_spi.size()) != 0 &&
             t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("drain", exp_eot.size() + exp_rx.size() + exp_spi.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic ok;
      logic [3:0] op;
      int r;
      int t;
      rst_n = 1'b0;
      div_in = 8'd0;
      div_vld = 1'b0;
      tx_data = 32'd0;
      tx_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {tx_rdy, cs_n, sclk, sdo, eot, rx_vld,
                         dut.spi_rx_en}, 7'b0100000);
      chk("reset_rx_data", rx_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rdy_after_reset", tx_rdy, 1'b1);
      mon_en = 1'b1;

      // Write with the reset divider of 4.
      send({4'hA, 4'hB, 8'h10, 16'hA001}, 32'd0);
      wait_done();

      // Read 16 bits from the slave.
      send({4'hB, 4'hB, 8'h10, 16'h0000}, 32'h5A3C);
      wait_done();

      // Read result held under backpressure blocks new commands.
      bp_hold = 1'b1;
      send({4'hB, 4'h5, 8'd8, 16'h0000}, 32'h000000C3);
      t = 0;
      while (exp_eot.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      tx_data = {4'hA, 4'h1, 8'd4, 16'h000F};
      tx_vld = 1'b1;
      ok = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (tx_rdy || !rx_vld) ok = 1'b0;
      end
      chk("bp_vld_hold_no_accept", ok, 1'b1);
      tx_vld = 1'b0;
      bp_hold = 1'b0;
      wait_done();

      // Unknown opcode: eot on the next cycle, no SPI frame.
      send({4'h3, 4'h0, 8'd8, 16'h1234}, 32'd0);
      chk("badop_eot", eot, 1'b1);
      chk("badop_cs_n", cs_n, 1'b1);
      wait_done();

      // Divider 0 acts as 1; a divider load mid-frame waits for idle.
      set_div(8'd0);
      send({4'hA, 4'h6, 8'd1, 16'h0001}, 32'd0);
      @(negedge clk);
      div_in = 8'd2;
      div_vld = 1'b1;
      wait_done();
      div_vld = 1'b0;
      div_model = 2;
      send({4'hA, 4'h9, 8'd5, 16'h0015}, 32'd0);
      wait_done();

      // Randomised commands, lengths, dividers and backpressure.
      bp_rand = 1'b1;
      for (int i = 0; i < 14; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4) op = 4'hA;
         else if (r < 8) op = 4'hB;
         else begin
            r = $urandom_range(0, 13);
            op = (r < 10) ? 4'(r) : 4'(r + 2);
         end
         if ($urandom_range(0, 2) == 0) set_div(8'($urandom_range(0, 5)));
         send({op, 4'($urandom), 8'($urandom_range(0, 40)),
               16'($urandom)}, $urandom);
         wait_done();
      end
      bp_rand = 1'b0;

      // Reset in the middle of a write aborts it silently.
      send({4'hA, 4'h9, 8'd16, 16'hBEEF}, 32'd0);
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      exp_spi.delete();
      exp_eot.delete();
      exp_rx.delete();
      @(posedge clk);
      #1;
      chk("abort_cs_n", cs_n, 1'b1);
      chk("abort_sclk", sclk, 1'b0);
      chk("abort_eot", eot, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      div_model = 4;
      repeat (20) @(negedge clk);
      send({4'hA, 4'h3, 8'd12, 16'h0ACE}, 32'd0);
      wait_done();

      chk("idle_levels", idle_viol, 0);
      chk("rdy_while_rx_vld", rdy_viol, 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
